// File: rtl/break_pkg.sv
// Shared types for the breakpoint unit: breakpoint kinds and controller states.
package break_pkg;

  localparam int unsigned KIND_W = 2;

  typedef enum logic [KIND_W-1:0] {
    BK_PC     = 2'd0,
    BK_IFETCH = 2'd1,
    BK_DREAD  = 2'd2,
    BK_DWRITE = 2'd3
  } bp_kind_e;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_STOPPED = 2'd1,
    ST_RESUME  = 2'd2
  } brk_state_e;

endpackage

// File: rtl/break_channel.sv
// One breakpoint channel: masked address compare on the selected monitor plus
// a saturating skip counter that decides whether a match actually fires.
module break_channel
  import break_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              pc_valid_i,
  input  logic [ADDR_W-1:0] iaddr_i,
  input  logic              ien_i,
  input  logic [ADDR_W-1:0] daddr_i,
  input  logic              den_i,
  input  logic              dwe_i,
  input  logic              en_i,
  input  bp_kind_e          kind_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [ADDR_W-1:0] mask_i,
  input  logic [CNT_W-1:0]  count_i,
  input  logic              load_i,
  output logic              fire_o_c
);

  logic [ADDR_W-1:0] mon_addr_c;
  logic              qual_c;
  logic              hit_c;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Select the monitored address and its qualifier by breakpoint kind.
  always_comb begin
    mon_addr_c = pc_i;
    qual_c     = pc_valid_i;
    case (kind_i)
      BK_PC: begin
        mon_addr_c = pc_i;
        qual_c     = pc_valid_i;
      end
      BK_IFETCH: begin
        mon_addr_c = iaddr_i;
        qual_c     = ien_i;
      end
      BK_DREAD: begin
        mon_addr_c = daddr_i;
        qual_c     = den_i && !dwe_i;
      end
      BK_DWRITE: begin
        mon_addr_c = daddr_i;
        qual_c     = den_i && dwe_i;
      end
      default: ;
    endcase
  end

  assign hit_c = arm_i && en_i && qual_c &&
                 (((mon_addr_c ^ addr_i) & ~mask_i) == '0);

  // A reload consumes the coincident match, so it can neither fire nor count.
  assign fire_o_c = hit_c && !load_i && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = count_i;
    end else if (hit_c && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/break_unit.sv
// Debug breakpoint unit: NUM_BP address channels plus single-step, stopping the
// core clock on a fire and resuming on a rising edge of the host continue level.
module break_unit
  import break_pkg::*;
#(
  parameter  int unsigned NUM_BP = 4,
  parameter  int unsigned ADDR_W = 32,
  parameter  int unsigned CNT_W  = 8,
  localparam int unsigned ID_W   = $clog2(NUM_BP) + 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ADDR_W-1:0]              pc,
  input  logic                           pc_valid,
  input  logic [ADDR_W-1:0]              iaddr,
  input  logic                           ien,
  input  logic [ADDR_W-1:0]              daddr,
  input  logic                           den,
  input  logic                           dwe,
  input  logic [NUM_BP-1:0]              bp_en,
  input  logic [NUM_BP-1:0][KIND_W-1:0]  bp_kind,
  input  logic [NUM_BP-1:0][ADDR_W-1:0]  bp_addr,
  input  logic [NUM_BP-1:0][ADDR_W-1:0]  bp_mask,
  input  logic [NUM_BP-1:0][CNT_W-1:0]   bp_count,
  input  logic [NUM_BP-1:0]              cnt_load,
  input  logic                           step_en,
  input  logic                           continue_req,
  output logic                           stop_clk,
  output logic                           stopped,
  output logic [NUM_BP-1:0]              hit_vec,
  output logic [ID_W-1:0]                hit_id
);

  brk_state_e        state_q, state_d;
  logic              stop_clk_q, stop_clk_d;
  logic              stopped_q, stopped_d;
  logic [NUM_BP-1:0] hit_vec_q, hit_vec_d;
  logic [ID_W-1:0]   hit_id_q, hit_id_d;
  logic              cont_q;
  logic              cont_rise_c;
  logic              arm_c;
  logic [NUM_BP-1:0] fire_c;
  logic [ID_W-1:0]   first_id_c;

  // Channels only evaluate while running; STOPPED and RESUME freeze matching.
  assign arm_c       = (state_q == ST_RUN);
  assign cont_rise_c = continue_req && !cont_q;

  for (genvar g = 0; g < NUM_BP; g++) begin : g_ch
    break_channel #(
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .arm_i      (arm_c),
      .pc_i       (pc),
      .pc_valid_i (pc_valid),
      .iaddr_i    (iaddr),
      .ien_i      (ien),
      .daddr_i    (daddr),
      .den_i      (den),
      .dwe_i      (dwe),
      .en_i       (bp_en[g]),
      .kind_i     (bp_kind_e'(bp_kind[g])),
      .addr_i     (bp_addr[g]),
      .mask_i     (bp_mask[g]),
      .count_i    (bp_count[g]),
      .load_i     (cnt_load[g]),
      .fire_o_c   (fire_c[g])
    );
  end

  // Lowest firing channel wins the cause code; zero means a step stop.
  always_comb begin
    first_id_c = '0;
    for (int i = int'(NUM_BP) - 1; i >= 0; i--) begin
      if (fire_c[i]) first_id_c = ID_W'(i + 1);
    end
  end

  always_comb begin
    state_d    = state_q;
    stop_clk_d = stop_clk_q;
    stopped_d  = stopped_q;
    hit_vec_d  = hit_vec_q;
    hit_id_d   = hit_id_q;
    case (state_q)
      ST_RUN: begin
        if ((|fire_c) || (step_en && pc_valid)) begin
          state_d    = ST_STOPPED;
          stop_clk_d = 1'b1;
          stopped_d  = 1'b1;
          hit_vec_d  = hit_vec_q | fire_c;
          hit_id_d   = first_id_c;
        end
      end
      ST_STOPPED: begin
        if (cont_rise_c) begin
          state_d    = ST_RESUME;
          stop_clk_d = 1'b0;
          stopped_d  = 1'b0;
          hit_vec_d  = '0;
          hit_id_d   = '0;
        end
      end
      ST_RESUME: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      stop_clk_q <= 1'b0;
      stopped_q  <= 1'b0;
      hit_vec_q  <= '0;
      hit_id_q   <= '0;
      cont_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      stop_clk_q <= stop_clk_d;
      stopped_q  <= stopped_d;
      hit_vec_q  <= hit_vec_d;
      hit_id_q   <= hit_id_d;
      cont_q     <= continue_req;
    end
  end

  assign stop_clk = stop_clk_q;
  assign stopped  = stopped_q;
  assign hit_vec  = hit_vec_q;
  assign hit_id   = hit_id_q;

endmodule

// File: tb/tb_break_unit.sv
// Self-checking bench for break_unit: directed scenarios plus a randomized run
// against a behavioural model of halting, resuming and skip counting.
module tb_break_unit;

  localparam int NUM_BP = 4;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 8;
  localparam logic [1:0] K_PC = 2'd0, K_IF = 2'd1, K_DR = 2'd2, K_DW = 2'd3;

  logic                          clk, reset;
  logic [ADDR_W-1:0]             pc, iaddr, daddr;
  logic                          pc_valid, ien, den, dwe;
  logic [NUM_BP-1:0]             bp_en;
  logic [NUM_BP-1:0][1:0]        bp_kind;
  logic [NUM_BP-1:0][ADDR_W-1:0] bp_addr, bp_mask;
  logic [NUM_BP-1:0][CNT_W-1:0]  bp_count;
  logic [NUM_BP-1:0]             cnt_load;
  logic                          step_en, continue_req;
  logic                          stop_clk, stopped;
  logic [NUM_BP-1:0]             hit_vec;
  logic [2:0]                    hit_id;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int          m_cnt [NUM_BP];
  bit          m_halted, m_resuming, m_prev_cont;
  bit          e_stop;
  logic [3:0]  e_hv;
  logic [2:0]  e_id;

  break_unit #(.NUM_BP(NUM_BP), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .pc(pc), .pc_valid(pc_valid), .iaddr(iaddr), .ien(ien),
    .daddr(daddr), .den(den), .dwe(dwe), .bp_en(bp_en), .bp_kind(bp_kind),
    .bp_addr(bp_addr), .bp_mask(bp_mask), .bp_count(bp_count), .cnt_load(cnt_load),
    .step_en(step_en), .continue_req(continue_req), .stop_clk(stop_clk),
    .stopped(stopped), .hit_vec(hit_vec), .hit_id(hit_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL timeout reached without finishing");
    $fatal(1);
  end

  function automatic bit tb_match(input int ch);
    logic [ADDR_W-1:0] a;
    bit q;
    case (bp_kind[ch])
      K_PC:    begin a = pc;    q = pc_valid;     end
      K_IF:    begin a = iaddr; q = ien;          end
      K_DR:    begin a = daddr; q = den && !dwe;  end
      default: begin a = daddr; q = den && dwe;   end
    endcase
    return bp_en[ch] && q && (((a ^ bp_addr[ch]) & ~bp_mask[ch]) == '0);
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit fire [NUM_BP];
    bit any, rise, looking;
    if (reset) begin
      m_halted = 0; m_resuming = 0; m_prev_cont = 0;
      e_stop = 0; e_hv = '0; e_id = '0;
      for (int c = 0; c < NUM_BP; c++) m_cnt[c] = 0;
      return;
    end
    rise        = continue_req && !m_prev_cont;
    m_prev_cont = continue_req;
    looking     = !m_halted && !m_resuming;
    any         = 0;
    for (int c = 0; c < NUM_BP; c++) begin
      fire[c] = 0;
      if (cnt_load[c]) m_cnt[c] = int'(bp_count[c]);
      else if (looking && tb_match(c)) begin
        if (m_cnt[c] == 0) begin fire[c] = 1; any = 1; end
        else m_cnt[c] = m_cnt[c] - 1;
      end
    end
    if (m_resuming) begin
      m_resuming = 0;
    end else if (m_halted) begin
      if (rise) begin
        m_halted = 0; m_resuming = 1; e_stop = 0; e_hv = '0; e_id = '0;
      end
    end else if (any || (step_en && pc_valid)) begin
      m_halted = 1; e_stop = 1; e_id = '0;
      for (int c = 0; c < NUM_BP; c++) begin
        if (fire[c]) e_hv[c] = 1'b1;
        if (fire[c] && e_id == 3'd0) e_id = 3'(c + 1);
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    reset = 0; pc = '0; iaddr = '0; daddr = '0;
    pc_valid = 0; ien = 0; den = 0; dwe = 0;
    bp_en = '0; bp_kind = '0; bp_addr = '0; bp_mask = '0; bp_count = '0;
    cnt_load = '0; step_en = 0; continue_req = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic set_bp(input int ch, input logic [1:0] kind, input logic [ADDR_W-1:0] addr,
                        input logic [ADDR_W-1:0] mask, input logic [CNT_W-1:0] cnt);
    bp_en[ch] = 1'b1; bp_kind[ch] = kind; bp_addr[ch] = addr; bp_mask[ch] = mask;
    bp_count[ch] = cnt; cnt_load[ch] = 1'b1;
    tick();
    cnt_load[ch] = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    tick(); tick();
    reset = 0;
    checks++;
    if ({stop_clk, stopped, hit_vec, hit_id} !== 9'd0) begin
      errors++;
      $display("FAIL reset_state got stop=%b stopped=%b hv=%b id=%0d want all 0",
               stop_clk, stopped, hit_vec, hit_id);
    end
  endtask

  task automatic test_pc_bp();
    do_reset();
    set_bp(0, K_PC, 32'h100, '0, 8'd0);
    pc = 32'h104; pc_valid = 1;
    tick();
    checks++;
    if (stop_clk !== 1'b0) begin
      errors++; $display("FAIL pc_nomatch stop_clk=%b want 0", stop_clk);
    end
    pc = 32'h100;
    tick();
    pc_valid = 0;
    checks++;
    if (stop_clk !== 1'b1 || stopped !== 1'b1 || hit_vec !== 4'b0001 || hit_id !== 3'd1) begin
      errors++;
      $display("FAIL pc_bp got stop=%b stopped=%b hv=%b id=%0d want 1 1 0001 1",
               stop_clk, stopped, hit_vec, hit_id);
    end
    tick(); tick();
    checks++;
    if (stop_clk !== 1'b1 || hit_vec !== 4'b0001) begin
      errors++; $display("FAIL pc_hold stop=%b hv=%b want 1 0001", stop_clk, hit_vec);
    end
    continue_req = 1;
    tick();
    continue_req = 0;
    checks++;
    if (stop_clk !== 1'b0 || stopped !== 1'b0 || hit_vec !== 4'b0000 || hit_id !== 3'd0) begin
      errors++;
      $display("FAIL pc_resume got stop=%b stopped=%b hv=%b id=%0d want 0 0 0000 0",
               stop_clk, stopped, hit_vec, hit_id);
    end
    tick();
  endtask

  task automatic test_dwrite_mask();
    do_reset();
    set_bp(1, K_DW, 32'h2000, 32'hF, 8'd0);
    daddr = 32'h200C; den = 1; dwe = 0;
    tick();
    checks++;
    if (stop_clk !== 1'b0) begin
      errors++; $display("FAIL dread_on_dwrite stop=%b want 0", stop_clk);
    end
    daddr = 32'h2010; dwe = 1;
    tick();
    checks++;
    if (stop_clk !== 1'b0) begin
      errors++; $display("FAIL dwrite_outside_mask stop=%b want 0", stop_clk);
    end
    daddr = 32'h200C;
    tick();
    den = 0; dwe = 0;
    checks++;
    if (stop_clk !== 1'b1 || hit_vec !== 4'b0010 || hit_id !== 3'd2) begin
      errors++;
      $display("FAIL dwrite_hit got stop=%b hv=%b id=%0d want 1 0010 2", stop_clk, hit_vec, hit_id);
    end
  endtask

  task automatic test_ifetch_count();
    do_reset();
    set_bp(2, K_IF, 32'h4000, '0, 8'd2);
    iaddr = 32'h4000; ien = 1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (stop_clk !== (k == 3)) begin
        errors++; $display("FAIL ifetch_count fetch %0d stop=%b want %b", k, stop_clk, k == 3);
      end
    end
    ien = 0;
    checks++;
    if (hit_vec !== 4'b0100 || hit_id !== 3'd3) begin
      errors++; $display("FAIL ifetch_cause hv=%b id=%0d want 0100 3", hit_vec, hit_id);
    end
  endtask

  task automatic test_simul_continue();
    do_reset();
    set_bp(0, K_PC, 32'h300, '0, 8'd0);
    set_bp(3, K_PC, 32'h300, '0, 8'd0);
    pc = 32'h300; pc_valid = 1;
    tick();
    checks++;
    if (stop_clk !== 1'b1 || hit_vec !== 4'b1001 || hit_id !== 3'd1) begin
      errors++;
      $display("FAIL simul_hit got stop=%b hv=%b id=%0d want 1 1001 1", stop_clk, hit_vec, hit_id);
    end
    continue_req = 1;
    tick();
    checks++;
    if (stop_clk !== 1'b0) begin
      errors++; $display("FAIL simul_resume stop=%b want 0", stop_clk);
    end
    tick();
    checks++;
    if (stop_clk !== 1'b0) begin
      errors++; $display("FAIL resume_rebreak stop=%b want 0", stop_clk);
    end
    pc_valid = 0;
    tick(); tick(); tick();
    checks++;
    if (stop_clk !== 1'b0) begin
      errors++; $display("FAIL held_continue_run stop=%b want 0", stop_clk);
    end
    pc_valid = 1;
    tick();
    pc_valid = 0;
    tick(); tick(); tick();
    checks++;
    if (stop_clk !== 1'b1) begin
      errors++; $display("FAIL held_continue_retrigger stop=%b want 1", stop_clk);
    end
    continue_req = 0;
    tick();
    continue_req = 1;
    tick();
    continue_req = 0;
    checks++;
    if (stop_clk !== 1'b0) begin
      errors++; $display("FAIL second_resume stop=%b want 0", stop_clk);
    end
    tick();
  endtask

  task automatic test_step();
    do_reset();
    step_en = 1;
    for (int k = 0; k < 3; k++) begin
      pc = 32'h1000 + 32'($urandom_range(0, 255)) * 4; pc_valid = 1;
      tick();
      pc_valid = 0;
      checks++;
      if (stop_clk !== 1'b1 || hit_id !== 3'd0 || hit_vec !== 4'b0000) begin
        errors++;
        $display("FAIL step_stop %0d got stop=%b hv=%b id=%0d want 1 0000 0", k, stop_clk, hit_vec, hit_id);
      end
      continue_req = 1;
      tick();
      continue_req = 0;
      tick(); tick();
      checks++;
      if (stop_clk !== 1'b0) begin
        errors++; $display("FAIL step_idle %0d stop=%b want 0", k, stop_clk);
      end
    end
    set_bp(0, K_PC, 32'h500, '0, 8'd0);
    pc = 32'h500; pc_valid = 1;
    tick();
    pc_valid = 0;
    checks++;
    if (stop_clk !== 1'b1 || hit_id !== 3'd1 || hit_vec !== 4'b0001) begin
      errors++;
      $display("FAIL step_with_bp got stop=%b hv=%b id=%0d want 1 0001 1", stop_clk, hit_vec, hit_id);
    end
    step_en = 0;
  endtask

  task automatic test_load_wins();
    do_reset();
    set_bp(0, K_PC, 32'h700, '0, 8'd0);
    pc = 32'h700; pc_valid = 1; bp_count[0] = 8'd1; cnt_load[0] = 1;
    tick();
    cnt_load[0] = 0;
    checks++;
    if (stop_clk !== 1'b0) begin
      errors++; $display("FAIL load_wins stop=%b want 0", stop_clk);
    end
    tick();
    checks++;
    if (stop_clk !== 1'b0) begin
      errors++; $display("FAIL load_then_count stop=%b want 0", stop_clk);
    end
    tick();
    pc_valid = 0;
    checks++;
    if (stop_clk !== 1'b1) begin
      errors++; $display("FAIL load_then_fire stop=%b want 1", stop_clk);
    end
  endtask

  task automatic test_stopped_freeze();
    do_reset();
    set_bp(0, K_PC, 32'h800, '0, 8'd0);
    set_bp(1, K_IF, 32'h900, '0, 8'd1);
    pc = 32'h800; pc_valid = 1;
    tick();
    pc_valid = 0; iaddr = 32'h900; ien = 1;
    tick(); tick(); tick();
    continue_req = 1;
    tick();
    continue_req = 0;
    tick();
    tick();
    checks++;
    if (stop_clk !== 1'b0) begin
      errors++; $display("FAIL freeze_count stop=%b want 0", stop_clk);
    end
    tick();
    ien = 0;
    checks++;
    if (stop_clk !== 1'b1 || hit_vec !== 4'b0010 || hit_id !== 3'd2) begin
      errors++;
      $display("FAIL freeze_fire got stop=%b hv=%b id=%0d want 1 0010 2", stop_clk, hit_vec, hit_id);
    end
  endtask

  task automatic test_reset_stopped();
    do_reset();
    set_bp(0, K_PC, 32'h600, '0, 8'd0);
    set_bp(1, K_IF, 32'h640, '0, 8'd3);
    pc = 32'h600; pc_valid = 1;
    tick();
    reset = 1;
    tick();
    reset = 0; pc_valid = 0;
    checks++;
    if ({stop_clk, stopped, hit_vec, hit_id} !== 9'd0) begin
      errors++;
      $display("FAIL reset_mid_stop got stop=%b stopped=%b hv=%b id=%0d want all 0",
               stop_clk, stopped, hit_vec, hit_id);
    end
    iaddr = 32'h640; ien = 1;
    tick();
    ien = 0;
    checks++;
    if (stop_clk !== 1'b1 || hit_vec !== 4'b0010 || hit_id !== 3'd2) begin
      errors++;
      $display("FAIL reset_clears_count got stop=%b hv=%b id=%0d want 1 0010 2", stop_clk, hit_vec, hit_id);
    end
  endtask

  task automatic test_random();
    logic [ADDR_W-1:0] mk;
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (cyc % 100 == 0) begin
        step_en = ($urandom_range(0, 3) == 0);
        for (int c = 0; c < NUM_BP; c++) begin
          case ($urandom_range(0, 3))
            0: mk = '0;
            1: mk = 32'h1;
            2: mk = 32'h3;
            default: mk = 32'hF;
          endcase
          bp_en[c]   = ($urandom_range(0, 3) != 0);
          bp_kind[c] = 2'($urandom_range(0, 3));
          bp_addr[c] = 32'($urandom_range(0, 15));
          bp_mask[c] = mk;
        end
      end
      pc = 32'($urandom_range(0, 15)); pc_valid = 1'($urandom_range(0, 1));
      iaddr = 32'($urandom_range(0, 15)); ien = 1'($urandom_range(0, 1));
      daddr = 32'($urandom_range(0, 15)); den = 1'($urandom_range(0, 1));
      dwe = 1'($urandom_range(0, 1));
      for (int c = 0; c < NUM_BP; c++) begin
        bp_count[c] = 8'($urandom_range(0, 3));
        cnt_load[c] = ($urandom_range(0, 15) == 0);
      end
      continue_req = ($urandom_range(0, 2) == 0);
      reset = ($urandom_range(0, 99) == 0);
      tick();
      checks++;
      if (stop_clk !== e_stop || stopped !== e_stop || hit_vec !== e_hv || hit_id !== e_id) begin
        errors++;
        $display("FAIL random cyc %0d got stop=%b stopped=%b hv=%b id=%0d want %b %b %b %0d",
                 cyc, stop_clk, stopped, hit_vec, hit_id, e_stop, e_stop, e_hv, e_id);
      end
    end
    reset = 0;
  endtask

  initial begin
    clear_inputs();
    m_halted = 0; m_resuming = 0; m_prev_cont = 0;
    e_stop = 0; e_hv = '0; e_id = '0;
    for (int c = 0; c < NUM_BP; c++) m_cnt[c] = 0;
    @(negedge clk);
    test_reset();
    test_pc_bp();
    test_dwrite_mask();
    test_ifetch_count();
    test_simul_continue();
    test_step();
    test_load_wins();
    test_stopped_freeze();
    test_reset_stopped();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/break_unit.md
BREAK_UNIT -- requirements
Module: break_unit

Interface
REQ-001 SHALL have parameter NUM_BP, default 4: number of breakpoint channels, 1..8.
REQ-002 SHALL have parameter ADDR_W, default 32: width of all monitored addresses.
REQ-003 SHALL have parameter CNT_W, default 8: width of each channel's hit counter.
REQ-004 SHALL have port clk, input, 1: the single clock; reset is synchronous and active-high.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have ports pc (input, ADDR_W) and pc_valid (input, 1): retiring PC, qualified by pc_valid.
REQ-007 SHALL have ports iaddr (input, ADDR_W) and ien (input, 1): instruction-memory monitor.
REQ-008 SHALL have ports daddr (input, ADDR_W), den (input, 1) and dwe (input, 1): data-memory monitor.
REQ-009 SHALL have ports bp_en (input, NUM_BP), bp_kind (input, NUM_BP x 2: 0=pc, 1=ifetch, 2=dread, 3=dwrite), bp_addr (input, NUM_BP x ADDR_W) and bp_mask (input, NUM_BP x ADDR_W; a 1 means don't-care bit).
REQ-010 SHALL have ports bp_count (input, NUM_BP x CNT_W: matches to ignore before stopping) and cnt_load (input, NUM_BP: reload pulse).
REQ-011 SHALL have ports step_en (input, 1: single-step mode) and continue_req (input, 1: level from host).
REQ-012 SHALL have outputs stop_clk (1), stopped (1), hit_vec (NUM_BP: sticky causes) and hit_id ($clog2(NUM_BP)+1: cause code).

Function
REQ-013 Channel match SHALL be ((mon_addr ^ bp_addr) & ~bp_mask)==0, ANDed with bp_en and the kind qualifier: pc_valid; ien; den&&!dwe; den&&dwe.
REQ-014 Each channel SHALL have a down-counter, loaded from bp_count on cnt_load; on a match with count>0 it decrements and no stop is raised; on a match with count==0 the channel fires; the counter SHALL saturate at 0.
REQ-015 FSM SHALL have states RUN, STOPPED and RESUME.
REQ-016 RUN -> STOPPED on any fire, or in step mode on pc_valid; stop_clk SHALL assert in the cycle after the fire (1-cycle latency, registered).
REQ-017 STOPPED SHALL hold stop_clk=1 and stopped=1 and ignore all monitors.
REQ-018 On a rising edge of continue_req in STOPPED, the FSM SHALL enter RESUME and drop stop_clk in the next cycle; a held-high level SHALL NOT re-trigger.
REQ-019 RESUME SHALL last exactly one cycle with matching suppressed, so the same access does not re-break; it then goes to RUN.
REQ-020 hit_vec SHALL OR in firing channels on entry to STOPPED and clear on the RESUME transition.
REQ-021 hit_id SHALL be 1 + the lowest-index firing channel; 0 means a step stop.
REQ-022 On simultaneous fires, all SHALL set hit_vec; hit_id SHALL take the lowest index.
REQ-023 Counters SHALL NOT decrement while in STOPPED or RESUME.
REQ-024 If cnt_load coincides with a match, load SHALL win.
REQ-025 Step mode SHALL NOT suppress address breakpoints.

Reset
REQ-026 Reset SHALL put the FSM in RUN and clear stop_clk, stopped, hit_vec, hit_id, all counters and the continue edge register.
REQ-027 Reset SHALL override every other event in the same cycle, including mid-STOPPED.

Structure
REQ-028 A shared package break_pkg SHALL hold the bp_kind enum (BK_PC, BK_IFETCH, BK_DREAD, BK_DWRITE) and the FSM state typedef.
REQ-029 Per-channel compare-and-count logic SHALL live in sub-module break_channel, instantiated NUM_BP times via generate.

Verification
REQ-030 Ch0 set to pc, addr 0x100, mask 0, count 0; drive pc=0x100 with pc_valid -> stop_clk=1 next cycle, hit_vec=0001, hit_id=1.
REQ-031 Ch1 set to dwrite, addr 0x2000, mask 0xF; drive a write to 0x200C -> stop; drive a read to 0x200C -> no stop.
REQ-032 Ch2 set to ifetch with count 2; fetch the address 3 times -> stop on the 3rd only.
REQ-033 Ch0 and ch3 hit in the same cycle -> hit_vec=1001, hit_id=1; hold continue_req high for 5 cycles -> exactly one resume; the same address present in the RESUME cycle -> no re-break.
REQ-034 step_en=1 with continue pulses -> one stop per pc_valid, hit_id=0.
REQ-035 Assert reset while STOPPED -> all outputs 0 and FSM in RUN next cycle.
